// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch FSM,
// one-entry hold buffer for words that arrive while ID is stalled, IF/ID register.
module if_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write_enable,
  input  logic            if_id_write_enable,
  input  logic            if_id_bubble_en,
  input  logic            ex_s_redirect_en,
  input  logic [XLEN-1:0] ex_s_redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_id_r_valid,
  output logic [XLEN-1:0] if_id_r_pc,
  output logic [XLEN-1:0] if_id_r_pc_plus4,
  output logic [XLEN-1:0] if_id_r_instr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_hold_valid;
  logic [XLEN-1:0] r_hold_pc;
  logic [XLEN-1:0] r_hold_instr;

  logic            w_req_valid;
  logic            w_accept;
  logic            w_deliver;
  logic            w_can_load;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_req_valid   = rst_n & (r_state == S_REQ) & pc_write_enable
                       & ~r_hold_valid & ~ex_s_redirect_en;
  assign w_accept      = w_req_valid & imem_req_ready;
  // Only a response to a live request in S_WAIT is a real instruction.
  assign w_deliver     = (r_state == S_WAIT) & imem_rsp_valid & ~ex_s_redirect_en;
  assign w_can_load    = if_id_write_enable & ~if_id_bubble_en & ~r_hold_valid;
  assign w_redirect_pc = {ex_s_redirect_pc[XLEN-1:2], 2'b00};

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      case (r_state)
        S_REQ: if (w_accept) begin
          r_req_pc <= r_pc;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid)        r_state <= S_REQ;
          else if (ex_s_redirect_en) r_state <= S_KILL;
        end
        S_KILL: if (imem_rsp_valid) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
      if (ex_s_redirect_en) r_pc <= w_redirect_pc;
      else if (w_accept)    r_pc <= r_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_valid     <= 1'b0;
      r_hold_pc        <= '0;
      r_hold_instr     <= NOP_INSTR;
      if_id_r_valid    <= 1'b0;
      if_id_r_pc       <= '0;
      if_id_r_pc_plus4 <= '0;
      if_id_r_instr    <= NOP_INSTR;
    end else begin
      if (ex_s_redirect_en) begin
        r_hold_valid <= 1'b0;
      end else if (if_id_write_enable & ~if_id_bubble_en & r_hold_valid) begin
        r_hold_valid <= 1'b0;
      end else if (w_deliver & ~if_id_bubble_en & ~w_can_load) begin
        r_hold_valid <= 1'b1;
        r_hold_pc    <= r_req_pc;
        r_hold_instr <= imem_rsp_data;
      end

      // Bubble keeps the pc fields so ID still sees a sane PC on a NOP.
      if (ex_s_redirect_en | if_id_bubble_en) begin
        if_id_r_valid <= 1'b0;
        if_id_r_instr <= NOP_INSTR;
      end else if (!if_id_write_enable) begin
        if_id_r_valid <= if_id_r_valid;
      end else if (r_hold_valid) begin
        if_id_r_valid    <= 1'b1;
        if_id_r_pc       <= r_hold_pc;
        if_id_r_pc_plus4 <= r_hold_pc + XLEN'(4);
        if_id_r_instr    <= r_hold_instr;
      end else if (w_deliver) begin
        if_id_r_valid    <= 1'b1;
        if_id_r_pc       <= r_req_pc;
        if_id_r_pc_plus4 <= r_req_pc + XLEN'(4);
        if_id_r_instr    <= imem_rsp_data;
      end else begin
        if_id_r_valid <= 1'b0;
        if_id_r_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic, all checked
// against a transaction-level model (outstanding fetch + kill flag + hold queue).
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, pwe, iwe, bub, redir, rdy, rspv;
  logic [31:0] rpc, rspd;
  logic        imem_req_valid, if_id_r_valid;
  logic [31:0] imem_req_addr, if_id_r_pc, if_id_r_pc_plus4, if_id_r_instr;

  int n_chk = 0;
  int n_fail = 0;

  if_stage #(.XLEN(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_write_enable(pwe), .if_id_write_enable(iwe), .if_id_bubble_en(bub),
    .ex_s_redirect_en(redir), .ex_s_redirect_pc(rpc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(rdy), .imem_rsp_valid(rspv), .imem_rsp_data(rspd),
    .if_id_r_valid(if_id_r_valid), .if_id_r_pc(if_id_r_pc),
    .if_id_r_pc_plus4(if_id_r_pc_plus4), .if_id_r_instr(if_id_r_instr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc, m_out_pc;
  logic        m_out, m_kill;
  logic [31:0] hq_pc[$];
  logic [31:0] hq_ins[$];
  logic        e_v, e_rv, e_acc, dut_acc;
  logic [31:0] e_pc, e_pc4, e_ins;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic i, input logic b,
                       input logic rd, input logic [31:0] rp, input logic ry,
                       input logic sv, input logic [31:0] sd);
    @(negedge clk);
    rst_n = r; pwe = p; iwe = i; bub = b; redir = rd; rpc = rp;
    rdy = ry; rspv = sv; rspd = sd;
    #1;
    e_rv    = r & ~m_out & p & (hq_pc.size() == 0) & ~rd;
    e_acc   = e_rv & ry;
    dut_acc = imem_req_valid & ry;
    if (!r) begin
      check("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
    end else begin
      check("req_valid", {31'd0, imem_req_valid}, {31'd0, e_rv});
      check("req_addr", imem_req_addr, m_pc);
      check("if_id_valid", {31'd0, if_id_r_valid}, {31'd0, e_v});
      check("if_id_pc", if_id_r_pc, e_pc);
      check("if_id_pc4", if_id_r_pc_plus4, e_pc4);
      check("if_id_instr", if_id_r_instr, e_ins);
    end
  endtask

  task automatic tick();
    logic        dlv, had;
    logic [31:0] dpc, dins;
    @(posedge clk);
    if (!rst_n) begin
      m_pc = RST_PC; m_out = 0; m_kill = 0; hq_pc.delete(); hq_ins.delete();
      e_v = 0; e_ins = NOP; e_pc = 0; e_pc4 = 0;
    end else begin
      dlv = 0; dpc = 0; dins = 0;
      if (m_out && rspv) begin
        m_out = 0;
        if (!m_kill && !redir) begin dlv = 1; dpc = m_out_pc; dins = rspd; end
      end else if (m_out && redir) begin
        m_kill = 1;
      end
      had = (hq_pc.size() != 0);
      if (redir || bub) begin
        e_v = 0; e_ins = NOP;
      end else if (!iwe) begin
        e_v = e_v;
      end else if (had) begin
        e_v = 1; e_pc = hq_pc.pop_front(); e_ins = hq_ins.pop_front(); e_pc4 = e_pc + 4;
      end else if (dlv) begin
        e_v = 1; e_pc = dpc; e_ins = dins; e_pc4 = dpc + 4;
      end else begin
        e_v = 0; e_ins = NOP;
      end
      if (redir) begin
        hq_pc.delete(); hq_ins.delete();
      end else if (dlv && !bub && !(iwe && !had)) begin
        hq_pc.push_back(dpc); hq_ins.push_back(dins);
      end
      if (redir) begin
        m_pc = rpc & 32'hFFFF_FFFC;
      end else if (e_acc) begin
        m_out = 1; m_out_pc = m_pc; m_kill = 0; m_pc = m_pc + 4;
      end
    end
  endtask

  logic        mem_pend;
  int          mem_cnt;
  logic        r_rst, r_pwe, r_iwe, r_bub, r_red, r_rdy, r_sv;
  logic [31:0] r_rpc;

  initial begin
    m_pc = RST_PC; m_out = 0; m_kill = 0; m_out_pc = 0;
    e_v = 0; e_pc = 0; e_pc4 = 0; e_ins = NOP;

    drive(0,1,1,0,0,0,0,0,0); tick();
    drive(0,1,1,0,0,0,0,0,0); tick();

    // First fetch and one-cycle response latency
    drive(1,1,1,0,0,0,1,0,0);
    check("rst_if_id_valid", {31'd0, if_id_r_valid}, 32'd0);
    check("rst_if_id_instr", if_id_r_instr, NOP);
    check("rst_if_id_pc", if_id_r_pc, 32'd0);
    check("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t1_req_addr", imem_req_addr, 32'h100);
    tick();
    drive(1,1,1,0,0,0,1,1,32'h0050_0093);
    check("t1_no_req_in_wait", {31'd0, imem_req_valid}, 32'd0);
    tick();

    // Back-pressure: three cycles of ready=0, then accept
    for (int k = 0; k < 3; k++) begin
      drive(1,1,1,0,0,0,0,0,0);
      if (k == 0) begin
        check("t1_if_id_valid", {31'd0, if_id_r_valid}, 32'd1);
        check("t1_if_id_pc", if_id_r_pc, 32'h100);
        check("t1_if_id_pc4", if_id_r_pc_plus4, 32'h104);
        check("t1_if_id_instr", if_id_r_instr, 32'h0050_0093);
      end
      check("t2_req_held", {31'd0, imem_req_valid}, 32'd1);
      check("t2_addr_stable", imem_req_addr, 32'h104);
      tick();
    end
    drive(1,1,1,0,0,0,1,0,0); tick();

    // Stall while the response arrives: word goes to the hold buffer
    drive(1,0,0,0,0,0,1,1,32'h00A0_0113);
    check("t3_stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    drive(1,1,1,0,0,0,1,0,0);
    check("t3_hold_blocks_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    drive(1,1,1,0,0,0,1,0,0);
    check("t3_held_valid", {31'd0, if_id_r_valid}, 32'd1);
    check("t3_held_pc", if_id_r_pc, 32'h104);
    check("t3_held_instr", if_id_r_instr, 32'h00A0_0113);
    check("t3_req_after", imem_req_addr, 32'h108);
    tick();

    // Redirect in S_WAIT, response two cycles later is dropped
    drive(1,1,1,0,1,32'h203,1,0,0); tick();
    drive(1,1,1,0,0,0,1,0,0);
    check("t4_kill_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    drive(1,1,1,0,0,0,1,1,32'hDEAD_BEEF); tick();
    drive(1,1,1,0,0,0,0,0,0);
    check("t4_if_id_valid", {31'd0, if_id_r_valid}, 32'd0);
    check("t4_if_id_instr", if_id_r_instr, NOP);
    check("t4_req_addr", imem_req_addr, 32'h200);
    tick();
    drive(1,1,1,0,0,0,1,0,0); tick();

    // Redirect coincident with the response
    drive(1,1,1,0,1,32'h200,1,1,32'h1111_1111); tick();
    drive(1,1,1,0,0,0,0,0,0);
    check("t5_if_id_valid", {31'd0, if_id_r_valid}, 32'd0);
    check("t5_req_addr", imem_req_addr, 32'h200);
    tick();
    drive(1,1,1,0,0,0,1,0,0); tick();

    // Reset mid-S_WAIT, stale response afterwards must be ignored
    drive(0,1,1,0,0,0,0,0,0); tick();
    drive(1,1,1,0,0,0,0,1,32'h2222_2222);
    check("t6_req_addr", imem_req_addr, RST_PC);
    tick();
    drive(1,1,1,0,0,0,1,0,0);
    check("t6_stale_ignored", {31'd0, if_id_r_valid}, 32'd0);
    tick();
    drive(1,1,1,0,0,0,1,1,32'h0050_0093); tick();
    drive(1,1,1,0,0,0,0,0,0);
    check("t6_real_valid", {31'd0, if_id_r_valid}, 32'd1);
    check("t6_real_pc", if_id_r_pc, RST_PC);
    tick();

    // Random traffic with a memory that answers 1..3 cycles after acceptance
    mem_pend = 0; mem_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      r_rst = ($urandom_range(199) != 0);
      r_pwe = ($urandom_range(5) != 0);
      r_iwe = ($urandom_range(5) != 0);
      r_bub = ($urandom_range(9) == 0);
      r_red = ($urandom_range(11) == 0);
      r_rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
      r_sv  = mem_pend && (mem_cnt == 0);
      r_rdy = !mem_pend && ($urandom_range(3) != 0);
      drive(r_rst, r_pwe, r_iwe, r_bub, r_red, r_rpc, r_rdy, r_sv, $urandom);
      tick();
      if (r_sv) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (dut_acc === 1'b1) begin
        mem_pend = 1; mem_cnt = $urandom_range(0, 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage with PC register and IF/ID pipeline register. It issues word fetches over a valid/ready instruction-memory request channel and tracks one outstanding request. It consumes the hazard unit's stall/flush outputs and the EX-stage redirect, and feeds the ID stage.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC after reset
NOP_INSTR, 32'h0000_0013, instruction word injected on bubbles (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
pc_write_enable  in  1  from hazard unit; 0 = hold PC, issue no request
if_id_write_enable  in  1  from hazard unit; 0 = IF/ID holds
if_id_bubble_en  in  1  from hazard unit; flush IF/ID to bubble
ex_s_redirect_en  in  1  branch taken or jump in EX
ex_s_redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  fetch request
imem_req_addr  out  XLEN  fetch address (word aligned)
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  XLEN  instruction word
if_id_r_valid  out  1  IF/ID holds a real instruction
if_id_r_pc  out  XLEN  PC of IF/ID instruction
if_id_r_pc_plus4  out  XLEN  if_id_r_pc + 4
if_id_r_instr  out  XLEN  instruction (NOP_INSTR when invalid)

Behaviour:
- Reset (rst_n=0 at edge): pc_r=RESET_PC, state=S_REQ, hold_valid=0, if_id_r_valid=0, if_id_r_instr=NOP_INSTR, if_id_r_pc=0, if_id_r_pc_plus4=0. imem_req_valid forced 0 while rst_n=0.
- Memory contract: at most one request outstanding. Exactly one response per accepted request, arriving no earlier than the cycle after acceptance. Responses received in S_REQ are ignored (including stale responses after a mid-operation reset).
- imem_req_addr = pc_r. imem_req_valid = (state==S_REQ) & pc_write_enable & ~hold_valid & ~ex_s_redirect_en. Address stays stable while valid & ~ready.
- FSM:
  - S_REQ: on valid&ready, req_pc<=pc_r, pc_r<=pc_r+4 (mod 2^XLEN wrap), go to S_WAIT.
  - S_WAIT: on rsp_valid & ~redirect, deliver (see below) and go to S_REQ. On rsp_valid & redirect, discard and go to S_REQ. On ~rsp_valid & redirect, go to S_KILL.
  - S_KILL: on rsp_valid, discard and go to S_REQ. Otherwise stay.
- Redirect (ex_s_redirect_en=1): pc_r<=ex_s_redirect_pc with bits[1:0] forced 0. Overrides increment and pc_write_enable. Clears hold_valid. IF/ID loads a bubble regardless of if_id_bubble_en.
- Delivery of a response word (req_pc, imem_rsp_data):
  - IF/ID can load (if_id_write_enable & ~if_id_bubble_en & ~hold_valid): word goes to IF/ID.
  - if_id_bubble_en=1: word is discarded.
  - Otherwise: word goes to the 1-entry hold buffer (hold_valid<=1).
- IF/ID update priority per edge:
  1. reset
  2. redirect or if_id_bubble_en: bubble (valid 0, NOP_INSTR, pc fields hold)
  3. ~if_id_write_enable: hold
  4. hold_valid: load buffer, clear hold_valid
  5. delivered response: load
  6. else: bubble
- Latency: rsp_valid in cycle M appears on if_id_r_* in cycle M+1. The next request is issued no earlier than M+1. Peak throughput is 1 instruction per 2 cycles with a zero-wait memory.
- if_id_r_pc_plus4 is registered together with if_id_r_pc and wraps mod 2^XLEN.

Test Plan:
- RESET_PC=0x100, ready=1, rsp 0x00500093 one cycle after acceptance -> req_addr 0x100; next cycle if_id_r_valid=1, pc=0x100, pc_plus4=0x104, instr=0x00500093; next req_addr 0x104.
- imem_req_ready=0 for 3 cycles -> req_valid held, addr stable at 0x104, pc_r unchanged; accepted on the 4th cycle.
- Stall (pc_write_enable=0, if_id_write_enable=0) in the cycle a response arrives -> IF/ID unchanged, hold_valid=1, no request. Release -> buffered word enters IF/ID, then a request is issued.
- Redirect to 0x203 while in S_WAIT, response 2 cycles later -> response discarded, if_id_r_valid=0 with NOP_INSTR, next req_addr 0x200.
- Redirect to 0x200 in the same cycle as rsp_valid -> response discarded, IF/ID bubble, req_addr 0x200 the following cycle.
- rst_n=0 mid-S_WAIT, then a stale rsp_valid after release -> ignored; first request at RESET_PC; if_id_r_valid stays 0 until a real response arrives.
